// File: rtl/mul_div_ctrl_if.sv
// Execute-stage handshake between the pipeline and the HI/LO multiply/divide sequencer.
interface mul_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 startE;
  logic [1:0]           opE;
  logic [WIDTH-1:0]     srcaE;
  logic [WIDTH-1:0]     srcbE;
  logic                 cancelE;
  logic                 mut_div_stallE;
  logic                 result_valid;
  logic [2*WIDTH-1:0]   hilo_out;
  logic                 busy;

  modport master (
    output startE, opE, srcaE, srcbE, cancelE,
    input  mut_div_stallE, result_valid, hilo_out, busy
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, cancelE,
    output mut_div_stallE, result_valid, hilo_out, busy
  );
endinterface

// File: rtl/mul_div_ctrl.sv
// HI/LO sequencer: counted-latency multiplier, iterative restoring divider and the
// control FSM that stalls F/D/E until the result can leave the execute stage.
module mul_div_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  mul_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CNT_W = (WIDTH > 16) ? $clog2(WIDTH) : 4;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed;
  logic [WIDTH-1:0]   r_srca;
  logic [WIDTH-1:0]   r_srcb;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_negQ;
  logic               r_negR;
  logic [2*WIDTH-1:0] r_hilo;
  logic               r_valid;
  logic               r_busy;

  logic               w_issue;
  logic               w_inSigned;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_extA;
  logic [2*WIDTH-1:0] w_extB;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quoNext;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  assign w_issue    = (r_state == IDLE) & bus.startE & ~bus.cancelE;
  assign w_inSigned = ~bus.opE[0];
  assign w_absA     = (w_inSigned & bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
  assign w_absB     = (w_inSigned & bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

  // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed one.
  assign w_extA = {{WIDTH{r_signed & r_srca[WIDTH-1]}}, r_srca};
  assign w_extB = {{WIDTH{r_signed & r_srcb[WIDTH-1]}}, r_srcb};
  assign w_prod = w_extA * w_extB;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = w_shift >= {1'b0, r_dvs};
  assign w_diff    = w_shift[WIDTH-1:0] - r_dvs;
  assign w_remNext = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quoNext = {r_quo[WIDTH-2:0], w_ge};
  assign w_quoFix  = r_negQ ? -w_quoNext : w_quoNext;
  assign w_remFix  = r_negR ? -w_remNext : w_remNext;

  assign bus.mut_div_stallE = w_issue | (r_state == MUL) | (r_state == DIV);
  assign bus.result_valid   = r_valid;
  assign bus.hilo_out       = r_hilo;
  assign bus.busy           = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_srca   <= '0;
      r_srcb   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_hilo   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_signed <= w_inSigned;
            r_srca   <= bus.srcaE;
            r_srcb   <= bus.srcbE;
            r_cnt    <= '0;
            r_quo    <= w_absA;
            r_rem    <= '0;
            r_dvs    <= w_absB;
            r_negQ   <= w_inSigned & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
            r_negR   <= w_inSigned & bus.srcaE[WIDTH-1];
            r_busy   <= 1'b1;
            if (!bus.opE[1]) begin
              r_state <= MUL;
            end else if (bus.srcbE == '0) begin
              r_hilo  <= {bus.srcaE, {WIDTH{1'b1}}};
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= DIV;
            end
          end
        end
        MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.cancelE) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_W'(MUL_LAT - 1)) begin
            r_hilo  <= w_prod;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          if (bus.cancelE) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_hilo  <= {w_remFix, w_quoFix};
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Directed and randomized checks of the HI/LO sequencer: latency, stall profile,
// signed/unsigned results, divide-by-zero, cancel and mid-operation reset.
module tb_mul_div_ctrl;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;
  localparam int MLAT    = MUL_LAT + 1;
  localparam int DLAT    = WIDTH + 1;

  logic clk = 1'b0;
  logic rst;
  int   nTests = 0;
  int   nFail  = 0;
  logic [63:0] expQ[$];

  mul_div_ctrl_if #(.WIDTH(WIDTH)) bus();

  mul_div_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference results built from native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = '0;
    case (op)
      2'b00: begin sq = sa * sb; res = sq; end
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Holds startE through the stall and DONE cycles, as the frozen E stage would.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp, input int lat);
    logic [63:0] want;
    expQ.push_back(exp);
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == lat) begin
        checkOutput({tag, " done flags"}, {61'd0, bus.busy, bus.mut_div_stallE, bus.result_valid}, 64'b101);
        want = expQ.pop_front();
        checkOutput({tag, " hilo"}, bus.hilo_out, want);
      end else begin
        checkOutput({tag, $sformatf(" flags c%0d", c)},
                    {61'd0, bus.busy, bus.mut_div_stallE, bus.result_valid},
                    (c == 0) ? 64'b010 : 64'b110);
      end
    end
    @(posedge clk); #1;
    bus.startE = 1'b0;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          rlat;

    rst         = 1'b1;
    bus.startE  = 1'b0;
    bus.opE     = 2'b00;
    bus.srcaE   = '0;
    bus.srcbE   = '0;
    bus.cancelE = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset flags", {61'd0, bus.busy, bus.mut_div_stallE, bus.result_valid}, 64'b000);
    checkOutput("reset hilo", bus.hilo_out, 64'd0);
    @(posedge clk); #1;

    applyStimulus("multu max*2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'h00000001_FFFFFFFE, MLAT);
    applyStimulus("mult -3*5",   2'b00, 32'hFFFF_FFFD, 32'd5,         64'hFFFFFFFF_FFFFFFF1, MLAT);
    applyStimulus("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, MLAT);
    applyStimulus("divu 100/7",  2'b11, 32'd100,       32'd7,         64'h00000002_0000000E, DLAT);
    applyStimulus("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD, DLAT);
    applyStimulus("div min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, DLAT);
    applyStimulus("div by zero", 2'b10, 32'h1234_5678, 32'd0,         64'h12345678_FFFFFFFF, 1);

    for (int i = 0; i < 6; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = (i == 5) ? 32'd0 : $urandom;
      rlat = !rop[1] ? MLAT : ((rb == 32'd0) ? 1 : DLAT);
      applyStimulus($sformatf("random op%0d", rop), rop, ra, rb, model(rop, ra, rb), rlat);
    end

    // Cancel a divide in its tenth cycle; no result may appear.
    bus.startE = 1'b1;
    bus.opE    = 2'b10;
    bus.srcaE  = 32'd1000;
    bus.srcbE  = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("cancel valid c%0d", c), {63'd0, bus.result_valid}, 64'd0);
      @(posedge clk); #1;
    end
    bus.cancelE = 1'b1;
    @(negedge clk);
    checkOutput("cancel valid c10", {63'd0, bus.result_valid}, 64'd0);
    @(posedge clk); #1;
    bus.cancelE = 1'b0;
    bus.startE  = 1'b0;
    @(negedge clk);
    checkOutput("cancel idle flags", {61'd0, bus.busy, bus.mut_div_stallE, bus.result_valid}, 64'b000);
    @(posedge clk); #1;
    applyStimulus("divu 9/3 after cancel", 2'b11, 32'd9, 32'd3, 64'h00000000_00000003, DLAT);

    // Start and cancel in the same IDLE cycle must not issue.
    bus.startE  = 1'b1;
    bus.cancelE = 1'b1;
    bus.opE     = 2'b01;
    @(negedge clk);
    checkOutput("idle cancel stall", {63'd0, bus.mut_div_stallE}, 64'd0);
    @(posedge clk); #1;
    bus.startE  = 1'b0;
    bus.cancelE = 1'b0;
    @(negedge clk);
    checkOutput("idle cancel busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;

    // Reset in cycle 5 of a divide discards it and clears hilo_out.
    bus.startE = 1'b1;
    bus.opE    = 2'b11;
    bus.srcaE  = 32'd50;
    bus.srcbE  = 32'd5;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.startE = 1'b0;
    @(negedge clk);
    checkOutput("midop reset flags", {61'd0, bus.busy, bus.mut_div_stallE, bus.result_valid}, 64'b000);
    checkOutput("midop reset hilo", bus.hilo_out, 64'd0);
    @(posedge clk); #1;

    applyStimulus("b2b multu first",  2'b01, 32'd7,        32'd6,        64'd42, MLAT);
    applyStimulus("b2b multu second", 2'b01, 32'h0000_FFFF, 32'h0001_0001,
                  model(2'b01, 32'h0000_FFFF, 32'h0001_0001), MLAT);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
